// File: rtl/uart_decoder_pkg.sv
// Shared framing constants and decoder state encoding for the blackjack UART link.
// The encoder and decoder both import this package so the wire format has one definition.
package uart_decoder_pkg;

   localparam int FRAME_LEN  = 10;
   localparam int IDX_STATUS = 0;
   localparam int IDX_LAST   = 9;
   localparam int NUM_CARDS  = FRAME_LEN - 1;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      COLLECT = 2'd1,
      COMMIT  = 2'd2
   } dec_state_t;

   // A status byte carries index 0 and keeps its two reserved top bits clear.
   function automatic logic is_status_byte(input logic [7:0] b);
      return (b[7:6] == 2'b00) && (b[3:0] == 4'(IDX_STATUS));
   endfunction

endpackage

// File: rtl/uart_decoder_if.sv
// Card-value bus between the UART decoder and the game state machine.
// The decoder drives it through the out (or master) modport; consumers use slave.
interface SM_if;
   import uart_decoder_pkg::*;

   logic [3:0] dealer_card_values [0:NUM_CARDS-1];

   modport out    (output dealer_card_values);
   modport master (output dealer_card_values);
   modport slave  (input  dealer_card_values);
endinterface

// File: rtl/uart_decoder_timeout.sv
// Idle-cycle watchdog for a partially received frame: counts while enabled,
// clears on every consumed byte, and holds expired once the limit is reached.
module uart_frame_timeout #(
   parameter int FRAME_TIMEOUT = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW = $clog2(FRAME_TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expired_o = (cnt_q == CW'(FRAME_TIMEOUT));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || !en_i) begin
         cnt_d = '0;
      end else if (!expired_o) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_decoder.sv
// Reassembles 10-byte status/card frames from the receive FIFO into a shadow copy
// and publishes them to the outputs atomically, counting any framing errors.
module uart_decoder
   import uart_decoder_pkg::*;
#(
   parameter int FRAME_TIMEOUT = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_empty,
   input  logic [7:0] r_data,
   output logic       rd_uart,
   SM_if.out          cards,
   output logic       deal,
   output logic       dealer_finished,
   output logic       frame_valid,
   output logic       frame_err,
   output logic [7:0] err_cnt
);

   dec_state_t state_q, state_d;
   logic [3:0] exp_q, exp_d;
   logic [3:0] shadow_q [0:NUM_CARDS-1];
   logic [3:0] shadow_d [0:NUM_CARDS-1];
   logic [3:0] card_q   [0:NUM_CARDS-1];
   logic [3:0] card_d   [0:NUM_CARDS-1];
   logic       sh_deal_q, sh_deal_d, sh_fin_q, sh_fin_d;
   logic       deal_q, deal_d, fin_q, fin_d;
   logic       fv_q, fv_d, fe_q, fe_d;
   logic [7:0] err_q, err_d;
   logic       err_inc;
   logic       expired;
   logic       status_ok;
   logic [3:0] idx;
   logic [3:0] slot;

   assign rd_uart   = !rx_empty && !rst;
   assign idx       = r_data[3:0];
   assign slot      = exp_q - 4'd1;
   assign status_ok = rd_uart && is_status_byte(r_data);

   uart_frame_timeout #(
      .FRAME_TIMEOUT(FRAME_TIMEOUT)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (rd_uart),
      .en_i     (state_q == COLLECT),
      .expired_o(expired)
   );

   always_comb begin
      state_d   = state_q;
      exp_d     = exp_q;
      shadow_d  = shadow_q;
      sh_deal_d = sh_deal_q;
      sh_fin_d  = sh_fin_q;
      card_d    = card_q;
      deal_d    = deal_q;
      fin_d     = fin_q;
      fv_d      = 1'b0;
      fe_d      = 1'b0;
      err_inc   = 1'b0;

      unique case (state_q)
         HUNT: begin
            if (status_ok) begin
               sh_deal_d = r_data[5];
               sh_fin_d  = r_data[4];
               exp_d     = 4'd1;
               state_d   = COLLECT;
            end
         end
         COLLECT: begin
            if (rd_uart) begin
               if (idx == exp_q) begin
                  shadow_d[slot] = r_data[7:4];
                  exp_d          = exp_q + 4'd1;
                  if (idx == 4'(IDX_LAST)) state_d = COMMIT;
               end else if (status_ok) begin
                  // A fresh status byte mid-frame is still an error, but it also opens the next frame.
                  err_inc   = 1'b1;
                  sh_deal_d = r_data[5];
                  sh_fin_d  = r_data[4];
                  exp_d     = 4'd1;
               end else begin
                  err_inc = 1'b1;
                  state_d = HUNT;
               end
            end else if (expired) begin
               err_inc = 1'b1;
               state_d = HUNT;
            end
         end
         COMMIT: begin
            card_d  = shadow_q;
            deal_d  = sh_deal_q;
            fin_d   = sh_fin_q;
            fv_d    = 1'b1;
            state_d = HUNT;
            if (status_ok) begin
               sh_deal_d = r_data[5];
               sh_fin_d  = r_data[4];
               exp_d     = 4'd1;
               state_d   = COLLECT;
            end
         end
         default: state_d = HUNT;
      endcase

      fe_d  = err_inc;
      err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= HUNT;
         exp_q     <= '0;
         shadow_q  <= '{default: '0};
         card_q    <= '{default: '0};
         sh_deal_q <= 1'b0;
         sh_fin_q  <= 1'b0;
         deal_q    <= 1'b0;
         fin_q     <= 1'b0;
         fv_q      <= 1'b0;
         fe_q      <= 1'b0;
         err_q     <= '0;
      end else begin
         state_q   <= state_d;
         exp_q     <= exp_d;
         shadow_q  <= shadow_d;
         card_q    <= card_d;
         sh_deal_q <= sh_deal_d;
         sh_fin_q  <= sh_fin_d;
         deal_q    <= deal_d;
         fin_q     <= fin_d;
         fv_q      <= fv_d;
         fe_q      <= fe_d;
         err_q     <= err_d;
      end
   end

   assign cards.dealer_card_values = card_q;
   assign deal            = deal_q;
   assign dealer_finished = fin_q;
   assign frame_valid     = fv_q;
   assign frame_err       = fe_q;
   assign err_cnt         = err_q;

endmodule

// File: tb/tb_uart_decoder.sv
// Directed bench for uart_decoder: frames are fed one byte per FIFO-not-empty cycle
// and every output is compared against hand-computed values.
module tb_uart_decoder;
   import uart_decoder_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_empty;
   logic [7:0] r_data;
   logic       rd_uart;
   logic       deal, fin, fv, fe;
   logic [7:0] err_cnt;

   SM_if cards_if ();

   uart_decoder #(.FRAME_TIMEOUT(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .rx_empty       (rx_empty),
      .r_data         (r_data),
      .rd_uart        (rd_uart),
      .cards          (cards_if),
      .deal           (deal),
      .dealer_finished(fin),
      .frame_valid    (fv),
      .frame_err      (fe),
      .err_cnt        (err_cnt)
   );

   always #5 clk = ~clk;

   int fv_cnt = 0, fe_cnt = 0, rd_bad = 0;
   int pass_cnt = 0, chk_cnt = 0;
   int fv_base, fe_base;

   always @(negedge clk) begin
      if (fv === 1'b1) fv_cnt <= fv_cnt + 1;
      if (fe === 1'b1) fe_cnt <= fe_cnt + 1;
      if (rd_uart === 1'b1 && rx_empty === 1'b1) rd_bad <= rd_bad + 1;
   end

   typedef logic [3:0] cards_t [0:NUM_CARDS-1];
   cards_t zero_c = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
   cards_t a_c    = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
   cards_t b_c    = '{15, 0, 7, 8, 3, 12, 5, 10, 1};
   cards_t c_c    = '{2, 4, 6, 8, 10, 12, 14, 1, 3};
   cards_t d_c    = '{9, 8, 7, 6, 5, 4, 3, 2, 1};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_cards(input string tag, input cards_t e);
      for (int i = 0; i < NUM_CARDS; i++)
         check($sformatf("%s_card%0d", tag, i), 32'(cards_if.dealer_card_values[i]), 32'(e[i]));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      r_data   = b;
      rx_empty = 1'b0;
      @(posedge clk);
      #1;
      rx_empty = 1'b1;
      idle(gap);
   endtask

   function automatic logic [7:0] frame_byte(input int n, input logic d, input logic f, input cards_t c);
      if (n == 0) return {2'b00, d, f, 4'h0};
      return {c[n-1], 4'(n)};
   endfunction

   task automatic send_frame(input logic d, input logic f, input cards_t c, input bit gaps);
      for (int n = 0; n < FRAME_LEN; n++)
         send(frame_byte(n, d, f, c), gaps ? int'($urandom_range(0, 5)) : 0);
   endtask

   initial begin
      rst      = 1'b1;
      rx_empty = 1'b1;
      r_data   = 8'h00;
      idle(2);
      rx_empty = 1'b0;
      #1;
      check("rd_in_reset", 32'(rd_uart), 0);
      rx_empty = 1'b1;
      check("rst_err", 32'(err_cnt), 0);
      check("rst_deal", 32'(deal), 0);
      check("rst_fin", 32'(fin), 0);
      check("rst_fv", 32'(fv), 0);
      check("rst_fe", 32'(fe), 0);
      check_cards("rst", zero_c);
      rst = 1'b0;
      idle(2);

      // Frame A back-to-back, with exact commit latency on byte 9.
      fv_base = fv_cnt;
      for (int n = 0; n < FRAME_LEN - 1; n++) send(frame_byte(n, 1'b1, 1'b0, a_c), 0);
      r_data   = frame_byte(9, 1'b1, 1'b0, a_c);
      rx_empty = 1'b0;
      @(posedge clk);
      #1;
      rx_empty = 1'b1;
      @(negedge clk);
      check("lat_fv_early", 32'(fv), 0);
      check("lat_card0_early", 32'(cards_if.dealer_card_values[0]), 0);
      @(negedge clk);
      check("lat_fv", 32'(fv), 1);
      check("lat_card0", 32'(cards_if.dealer_card_values[0]), 1);
      idle(3);
      check("a_fv_cnt", 32'(fv_cnt - fv_base), 1);
      check("a_fe_cnt", 32'(fe_cnt), 0);
      check("a_deal", 32'(deal), 1);
      check("a_fin", 32'(fin), 0);
      check("a_err", 32'(err_cnt), 0);
      check_cards("a", a_c);

      // Gapped frames: a distinct frame with full nibble range, then frame A again.
      send_frame(1'b0, 1'b1, b_c, 1'b1);
      idle(3);
      check("b_deal", 32'(deal), 0);
      check("b_fin", 32'(fin), 1);
      check_cards("b", b_c);
      fv_base = fv_cnt;
      send_frame(1'b1, 1'b0, a_c, 1'b1);
      idle(3);
      check("gap_fv_cnt", 32'(fv_cnt - fv_base), 1);
      check("gap_deal", 32'(deal), 1);
      check("gap_fin", 32'(fin), 0);
      check_cards("gap", a_c);
      check("gap_rd_while_empty", 32'(rd_bad), 0);
      check("gap_err", 32'(err_cnt), 0);

      // Skipped byte 3.
      fv_base = fv_cnt;
      fe_base = fe_cnt;
      send(8'h00, 0); send(8'h11, 0); send(8'h22, 0); send(8'h44, 0);
      idle(3);
      check("skip_fe_cnt", 32'(fe_cnt - fe_base), 1);
      check("skip_err", 32'(err_cnt), 1);
      check("skip_fv_cnt", 32'(fv_cnt - fv_base), 0);
      check_cards("skip", a_c);
      send_frame(1'b0, 1'b0, c_c, 1'b0);
      idle(3);
      check("skip_next_fv", 32'(fv_cnt - fv_base), 1);
      check("skip_next_deal", 32'(deal), 0);
      check_cards("skip_next", c_c);

      // Restart with a new status byte mid-frame.
      fv_base = fv_cnt;
      send(8'h30, 0); send(8'h11, 0); send(8'h22, 0);
      send_frame(1'b0, 1'b1, d_c, 1'b0);
      idle(3);
      check("rs_err", 32'(err_cnt), 2);
      check("rs_fv_cnt", 32'(fv_cnt - fv_base), 1);
      check("rs_deal", 32'(deal), 0);
      check("rs_fin", 32'(fin), 1);
      check_cards("rs", d_c);

      // Index-0 byte with reserved bits set mid-frame aborts to HUNT.
      send(8'h20, 0); send(8'h11, 0); send(8'hC0, 0);
      send(8'h22, 0);
      idle(3);
      check("bad0_err", 32'(err_cnt), 3);
      check_cards("bad0", d_c);

      // Timeout after byte 4.
      fv_base = fv_cnt;
      fe_base = fe_cnt;
      for (int n = 0; n < 5; n++) send(frame_byte(n, 1'b1, 1'b1, a_c), 0);
      idle(15);
      check("to_early", 32'(fe_cnt - fe_base), 0);
      idle(6);
      check("to_fe_cnt", 32'(fe_cnt - fe_base), 1);
      check("to_err", 32'(err_cnt), 4);
      for (int n = 5; n < FRAME_LEN; n++) send(frame_byte(n, 1'b1, 1'b1, a_c), 0);
      idle(3);
      check("to_late_fe", 32'(fe_cnt - fe_base), 1);
      check("to_late_fv", 32'(fv_cnt - fv_base), 0);
      check("to_late_deal", 32'(deal), 0);
      check_cards("to_late", d_c);

      // Reset after byte 6 of a frame.
      fv_base = fv_cnt;
      fe_base = fe_cnt;
      for (int n = 0; n < 7; n++) send(frame_byte(n, 1'b1, 1'b0, c_c), 0);
      rst = 1'b1;
      idle(2);
      check("mrst_err", 32'(err_cnt), 0);
      check("mrst_fin", 32'(fin), 0);
      check_cards("mrst", zero_c);
      rst = 1'b0;
      idle(2);
      check("mrst_no_fv", 32'(fv_cnt - fv_base), 0);
      check("mrst_no_fe", 32'(fe_cnt - fe_base), 0);
      send_frame(1'b1, 1'b0, a_c, 1'b0);
      idle(3);
      check("mrst_next_fv", 32'(fv_cnt - fv_base), 1);
      check("mrst_next_deal", 32'(deal), 1);
      check_cards("mrst_next", a_c);

      // 300 bad frames drive the error counter into saturation.
      for (int k = 0; k < 300; k++) begin
         send(8'h20, 0); send(8'h11, 0); send(8'h13, 0);
      end
      idle(3);
      check("sat_err", 32'(err_cnt), 32'hFF);
      check_cards("sat", a_c);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, observed %0d/%0d", pass_cnt, chk_cnt);
      $fatal(1, "watchdog");
   end

endmodule
